// File: rtl/mips_pkg.sv
// Shared MIPS ALU control codes and the multiply/divide FSM state encoding.
// Imported by the ALU decoder and by muldiv_unit so both agree on the codes.
package mips_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_DIV  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
// The unit is the slave; the pipeline (or bench) is the master.
interface muldiv_unit_if;

  logic        start;
  logic [3:0]  alucontrol;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, alucontrol, srca, srcb, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, alucontrol, srca, srcb, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed MULT/DIV: 32 cycles of shift-add or restoring division, done pulse at cycle 33.
// Stalls the pipeline via busy from acceptance until DONE; start is ignored while busy, flush aborts.
module muldiv_unit
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  md_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] work_q, work_d;
  logic [31:0] opb_q, opb_d;
  logic        neg_lo_q, neg_lo_d;
  logic        neg_hi_q, neg_hi_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] rem_sh;
  logic [31:0] rem_sub;
  logic        div_ge;
  logic [63:0] div_step;
  logic [63:0] prod_s;
  logic [31:0] quot_s, rem_s, dz_hi;
  logic        op_ok;

  assign mag_a = bus.srca[31] ? (~bus.srca + 32'd1) : bus.srca;
  assign mag_b = bus.srcb[31] ? (~bus.srcb + 32'd1) : bus.srcb;
  assign op_ok = (bus.alucontrol == ALU_MULT) || (bus.alucontrol == ALU_DIV);

  // Multiply: upper half accumulates the multiplicand, the 33rd bit is the carry shifted back in.
  assign mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_step = {mul_sum, work_q[31:1]};

  // Divide: {remainder, dividend} shifts left; a quotient bit enters at the bottom.
  assign rem_sh   = work_q[63:31];
  assign rem_sub  = rem_sh[31:0] - opb_q;
  assign div_ge   = rem_sh >= {1'b0, opb_q};
  assign div_step = div_ge ? {rem_sub, work_q[30:0], 1'b1}
                           : {rem_sh[31:0], work_q[30:0], 1'b0};

  assign prod_s = neg_lo_q ? (~mul_step + 64'd1) : mul_step;
  assign quot_s = neg_lo_q ? (~div_step[31:0] + 32'd1) : div_step[31:0];
  assign rem_s  = neg_hi_q ? (~div_step[63:32] + 32'd1) : div_step[63:32];
  assign dz_hi  = neg_hi_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opb_d    = opb_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush && op_ok) begin
          cnt_d    = 6'd0;
          neg_lo_d = bus.srca[31] ^ bus.srcb[31];
          neg_hi_d = bus.srca[31];
          if (bus.alucontrol == ALU_MULT) begin
            state_d = MUL;
            work_d  = {32'd0, mag_b};
            opb_d   = mag_a;
          end else begin
            state_d = DIV;
            work_d  = {32'd0, mag_a};
            opb_d   = mag_b;
          end
        end
      end
      MUL: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          work_d = mul_step;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d      = DONE;
            {hi_d, lo_d} = prod_s;
          end
        end
      end
      DIV: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (opb_q == 32'd0) begin
          state_d = DONE;
          lo_d    = 32'hFFFF_FFFF;
          hi_d    = dz_hi;
        end else begin
          work_d = div_step;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = DONE;
            lo_d    = quot_s;
            hi_d    = rem_s;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      work_q   <= 64'd0;
      opb_q    <= 32'd0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opb_q    <= opb_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed spec cases, flush/reset scenarios and
// randomized operands against a plain-arithmetic signed multiply/divide model.
module tb_muldiv_unit;
  import mips_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  muldiv_unit_if bus();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  // {hi,lo} for the requested op, straight from signed arithmetic rules.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint pa, pb;
    if (op == ALU_MULT) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return 64'(pa * pb);
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 40));
      4:       return 32'(-$signed(32'($urandom_range(1, 40))));
      default: return $urandom;
    endcase
  endfunction

  // Issues one request, then watches up to 40 cycles. Cycle 1 is the first after acceptance.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_cyc, input int poke_cyc,
                        output int done_cyc, output int done_cnt, output int idle_cyc,
                        output logic [31:0] hi_o, output logic [31:0] lo_o);
    bus.alucontrol = op;
    bus.srca       = a;
    bus.srcb       = b;
    bus.flush      = 1'b0;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    done_cyc  = -1;
    done_cnt  = 0;
    idle_cyc  = -1;
    hi_o      = '0;
    lo_o      = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      hi_o = bus.hi;
      lo_o = bus.lo;
      if (!bus.busy) begin
        idle_cyc = cyc;
        break;
      end
      if (cyc == flush_cyc) bus.flush = 1'b1;
      if (cyc == poke_cyc) begin
        bus.start      = 1'b1;
        bus.alucontrol = ALU_DIV;
        bus.srca       = $urandom;
        bus.srcb       = 32'd3;
      end
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.flush      = 1'b0;
    bus.alucontrol = 4'd0;
    bus.srca       = 32'd0;
    bus.srcb       = 32'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
    n_checks++;
    if (bus.hi !== 32'd0) $display("FAIL reset_hi: got %h want 0", bus.hi); else n_pass++;
    n_checks++;
    if (bus.lo !== 32'd0) $display("FAIL reset_lo: got %h want 0", bus.lo); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_directed();
    vec_t v[7];
    int dc, dn, ic;
    logic [31:0] h, l;
    v[0] = '{ALU_MULT, 32'd7,          32'd6,          32'd0,          32'd42,         33};
    v[1] = '{ALU_MULT, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF,  32'hFFFF_FFF1,  33};
    v[2] = '{ALU_MULT, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'd1,          33};
    v[3] = '{ALU_DIV,  32'd100,        32'd7,          32'd2,          32'd14,         33};
    v[4] = '{ALU_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  33};
    v[5] = '{ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
    v[6] = '{ALU_DIV,  32'd55,         32'd0,          32'd55,         32'hFFFF_FFFF,  2};
    for (int i = 0; i < 7; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, -1, -1, dc, dn, ic, h, l);
      n_checks++;
      if ({h, l} !== {v[i].hi, v[i].lo})
        $display("FAIL dir%0d_result: got %h_%h want %h_%h", i, h, l, v[i].hi, v[i].lo);
      else n_pass++;
      n_checks++;
      if (dc != v[i].cyc || dn != 1)
        $display("FAIL dir%0d_done: got cycle %0d count %0d want cycle %0d count 1",
                 i, dc, dn, v[i].cyc);
      else n_pass++;
      n_checks++;
      if (ic != v[i].cyc + 1)
        $display("FAIL dir%0d_busy: idle at %0d want %0d", i, ic, v[i].cyc + 1);
      else n_pass++;
    end
  endtask

  task automatic test_busy_start();
    int dc, dn, ic;
    logic [31:0] h, l;
    run_op(ALU_MULT, 32'd7, 32'd6, -1, 5, dc, dn, ic, h, l);
    n_checks++;
    if ({h, l} !== ref_result(ALU_MULT, 32'd7, 32'd6) || dc != 33 || ic != 34)
      $display("FAIL busy_start: got %h_%h done %0d idle %0d want %h done 33 idle 34",
               h, l, dc, ic, ref_result(ALU_MULT, 32'd7, 32'd6));
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL busy_start_queued: busy %b want 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_flush();
    int dc, dn, ic, late_done;
    logic [31:0] h, l;
    logic [63:0] prior;
    prior = ref_result(ALU_MULT, 32'd7, 32'd6);
    run_op(ALU_MULT, 32'd1234, 32'd5678, 10, -1, dc, dn, ic, h, l);
    late_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done) late_done++;
    end
    n_checks++;
    if (ic != 11) $display("FAIL flush_idle: idle at %0d want 11", ic); else n_pass++;
    n_checks++;
    if (dn + late_done != 0) $display("FAIL flush_done: %0d pulses want 0", dn + late_done);
    else n_pass++;
    n_checks++;
    if ({h, l} !== prior) $display("FAIL flush_hold: got %h_%h want %h", h, l, prior);
    else n_pass++;
  endtask

  task automatic test_flush_in_done();
    int dc, dn, ic;
    logic [31:0] h, l;
    run_op(ALU_DIV, 32'd100, 32'd7, 33, -1, dc, dn, ic, h, l);
    n_checks++;
    if ({h, l} !== {32'd2, 32'd14} || dn != 1 || ic != 34)
      $display("FAIL flush_in_done: got %h_%h done %0d idle %0d want 00000002_0000000e 1 34",
               h, l, dn, ic);
    else n_pass++;
  endtask

  task automatic test_ignore();
    bus.alucontrol = ALU_MULT;
    bus.srca       = 32'd3;
    bus.srcb       = 32'd3;
    bus.start      = 1'b1;
    bus.flush      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL flush_priority: busy %b want 0", bus.busy);
    else n_pass++;
    @(negedge clk);
    bus.alucontrol = ALU_ADD;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL bad_op_ignored: busy %b want 0", bus.busy);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random();
    int dc, dn, ic, exp_cyc;
    logic [31:0] a, b, h, l;
    logic [3:0] op;
    logic [63:0] exp;
    for (int i = 0; i < 24; i++) begin
      op = ($urandom_range(0, 1) == 0) ? ALU_MULT : ALU_DIV;
      a  = pick_operand();
      b  = pick_operand();
      exp     = ref_result(op, a, b);
      exp_cyc = (op == ALU_DIV && b == 32'd0) ? 2 : 33;
      run_op(op, a, b, -1, -1, dc, dn, ic, h, l);
      n_checks++;
      if ({h, l} !== exp)
        $display("FAIL rand%0d op=%h a=%h b=%h: got %h_%h want %h", i, op, a, b, h, l, exp);
      else n_pass++;
      n_checks++;
      if (dc != exp_cyc || dn != 1 || ic != exp_cyc + 1)
        $display("FAIL rand%0d_timing: done %0d x%0d idle %0d want done %0d x1 idle %0d",
                 i, dc, dn, ic, exp_cyc, exp_cyc + 1);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int dc, dn, ic, stray;
    logic [31:0] h, l;
    run_op(ALU_MULT, 32'd1000, 32'd3000, -1, -1, dc, dn, ic, h, l);
    bus.alucontrol = ALU_DIV;
    bus.srca       = 32'd1000;
    bus.srcb       = 32'd7;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 15; c++) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL reset_mid_state: busy %b done %b want 0 0", bus.busy, bus.done);
    else n_pass++;
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'd0)
      $display("FAIL reset_mid_regs: got %h_%h want 0", bus.hi, bus.lo);
    else n_pass++;
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done || bus.busy) stray++;
    end
    reset = 1'b1;
    run_op(ALU_MULT, 32'd2, 32'd3, -1, -1, dc, dn, ic, h, l);
    n_checks++;
    if (stray != 0 || dn != 1 || dc != 33)
      $display("FAIL reset_mid_done: stray %0d done %0d at %0d want 0 1 33", stray, dn, dc);
    else n_pass++;
    n_checks++;
    if ({h, l} !== 64'd6) $display("FAIL reset_mid_mult: got %h_%h want 0_6", h, l);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    @(negedge clk);
    test_directed();
    test_busy_start();
    test_flush();
    test_flush_in_done();
    test_ignore();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL expose: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL expose: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL expose: start  input  1  request from execute stage, qualified by alucontrol.
REQ-004 SHALL expose: alucontrol  input  4  ALU control code from the ALU decoder; 4'b1000 = MULT, 4'b1001 = DIV.
REQ-005 SHALL expose: srca  input  32  signed operand A (multiplicand / dividend).
REQ-006 SHALL expose: srcb  input  32  signed operand B (multiplier / divisor).
REQ-007 SHALL expose: flush  input  1  abort the operation in flight (pipeline flush).
REQ-008 SHALL expose: busy  output  1  high while an operation is in flight; drives pipeline stall.
REQ-009 SHALL expose: done  output  1  one-cycle pulse when hi/lo are updated.
REQ-010 SHALL expose: hi  output  32  HI register (product upper word / remainder).
REQ-011 SHALL expose: lo  output  32  LO register (product lower word / quotient).

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-013 SHALL accept a request only in IDLE, only when start=1 and alucontrol is MULT or DIV; otherwise start is ignored.
REQ-014 SHALL latch operand magnitudes and result sign at acceptance; the cycle of acceptance is cycle 0.
REQ-015 SHALL run 32 shift-add iterations in MUL (cycles 1..32), one bit per cycle, on unsigned magnitudes.
REQ-016 SHALL run 32 restoring-division iterations in DIV (cycles 1..32), one quotient bit per cycle, on unsigned magnitudes.
REQ-017 SHALL enter DONE at cycle 33, write hi/lo with the sign-corrected result, pulse done for exactly that cycle, and return to IDLE at cycle 34.
REQ-018 SHALL produce MULT result {hi,lo} = full 64-bit signed two's-complement product.
REQ-019 SHALL produce DIV result lo = quotient truncated toward zero and hi = remainder carrying the sign of the dividend.
REQ-020 SHALL handle -2^31 / -1 as lo=32'h8000_0000, hi=0, with no exception.
REQ-021 SHALL handle divide by zero by going directly from DIV to DONE at cycle 2 with lo=32'hFFFF_FFFF and hi=srca.
REQ-022 SHALL drive busy=1 in MUL, DIV and DONE, and busy=0 in IDLE.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL, on flush=1 in MUL or DIV, return to IDLE next cycle with hi/lo unchanged and no done pulse.
REQ-025 SHALL let flush in DONE have no effect (result commits); flush in IDLE is ignored.
REQ-026 SHALL give flush priority over start in the same cycle; no request is accepted that cycle.
REQ-027 SHALL hold hi/lo stable except in DONE; they are readable (mfhi/mflo) at all times.

Reset
REQ-028 SHALL, on reset=0, asynchronously force state IDLE, busy=0, done=0, hi=0, lo=0, and clear iteration counter and datapath registers.
REQ-029 SHALL abandon any operation in flight on reset mid-operation, with no done pulse after release.
REQ-030 SHALL, after reset release, accept start on the first rising edge.

Structure
REQ-031 SHALL place ALU control codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_MULT, ALU_DIV) and the muldiv FSM state enum in shared package mips_pkg, used by both the ALU decoder and this block.
REQ-032 SHALL use a 6-bit iteration counter and 64-bit working register; no sub-module is needed, keeping FSM and datapath in one module.

Verification
REQ-033 Bench SHALL check MULT 7 x 6 -> busy cycles 1..33, done at cycle 33, hi=0, lo=42.
REQ-034 Bench SHALL check MULT -3 x 5 -> hi=FFFF_FFFF, lo=FFFF_FFF1; MULT FFFF_FFFF x FFFF_FFFF -> hi=0, lo=1.
REQ-035 Bench SHALL check DIV 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=FFFF_FFFD, hi=FFFF_FFFF; DIV 8000_0000/FFFF_FFFF -> lo=8000_0000, hi=0.
REQ-036 Bench SHALL check DIV 55/0 -> done at cycle 2, lo=FFFF_FFFF, hi=55.
REQ-037 Bench SHALL check flush at cycle 10 of a MULT -> IDLE at cycle 11, hi/lo keep prior values, no done; start during busy is ignored.
REQ-038 Bench SHALL check reset=0 at cycle 15 of a DIV -> immediate IDLE, hi=lo=0, no done; a new MULT 2 x 3 after release gives lo=6.
